// File: rtl/mem_arb_pkg.sv
// Shared types and width helpers for the fetch/LSU memory port arbiter.
// Imported by the interface, the arbiter top and the perf-counter block.
package mem_arb_pkg;

    // Owner of the read response that returns in the next cycle
    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IF,
        OWN_LS
    } owner_t;

    localparam int DEFAULT_MAX_LS_BURST = 4;
    localparam int STREAK_W             = $clog2(DEFAULT_MAX_LS_BURST + 1);

    function automatic int streak_width(input int max_burst);
        return $clog2(max_burst + 1);
    endfunction

    function automatic int mask_width(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, LSU, memory-macro and perf-counter signals around mem_port_arbiter.
// slave = arbiter side, master = surrounding core/memory side.
interface mem_port_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int MASK_W = mask_width(DATA_W);

    logic              i_if_req;
    logic [ADDR_W-1:0] i_if_addr;
    logic              o_if_gnt;
    logic              o_if_rvalid;
    logic [DATA_W-1:0] o_if_rdata;

    logic              i_ls_req;
    logic              i_ls_wren;
    logic [ADDR_W-1:0] i_ls_addr;
    logic [DATA_W-1:0] i_ls_wdata;
    logic [MASK_W-1:0] i_ls_bmask;
    logic              o_ls_gnt;
    logic              o_ls_rvalid;
    logic [DATA_W-1:0] o_ls_rdata;

    logic              o_mem_en;
    logic              o_mem_wren;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [DATA_W-1:0] o_mem_wdata;
    logic [MASK_W-1:0] o_mem_bmask;
    logic [DATA_W-1:0] i_mem_rdata;

    logic [31:0]       o_conflict_cnt;
    logic [31:0]       o_starve_cnt;

    modport slave (
        input  i_if_req, i_if_addr,
        output o_if_gnt, o_if_rvalid, o_if_rdata,
        input  i_ls_req, i_ls_wren, i_ls_addr, i_ls_wdata, i_ls_bmask,
        output o_ls_gnt, o_ls_rvalid, o_ls_rdata,
        output o_mem_en, o_mem_wren, o_mem_addr, o_mem_wdata, o_mem_bmask,
        input  i_mem_rdata,
        output o_conflict_cnt, o_starve_cnt
    );

    modport master (
        output i_if_req, i_if_addr,
        input  o_if_gnt, o_if_rvalid, o_if_rdata,
        output i_ls_req, i_ls_wren, i_ls_addr, i_ls_wdata, i_ls_bmask,
        input  o_ls_gnt, o_ls_rvalid, o_ls_rdata,
        input  o_mem_en, o_mem_wren, o_mem_addr, o_mem_wdata, o_mem_bmask,
        output i_mem_rdata,
        input  o_conflict_cnt, o_starve_cnt
    );

endinterface

// File: rtl/mem_arb_perf.sv
// Saturating arbitration perf counters: request conflicts and forced fetch grants.
// Only instantiated when MEM_ARB_PERF_EN is defined.
module mem_arb_perf (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        conflict,
    input  logic        forced,
    output logic [31:0] conflict_cnt,
    output logic [31:0] starve_cnt
);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            conflict_cnt <= '0;
            starve_cnt   <= '0;
        end else begin
            if (conflict && conflict_cnt != 32'hFFFF_FFFF) conflict_cnt <= conflict_cnt + 32'd1;
            if (forced && starve_cnt != 32'hFFFF_FFFF)     starve_cnt   <= starve_cnt + 32'd1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and LSU with bounded fetch starvation.
// Optional perf counters are built when MEM_ARB_PERF_EN is defined; otherwise they read 0.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MAX_LS_BURST = DEFAULT_MAX_LS_BURST
) (
    input  logic               i_clk,
    input  logic               i_reset,
    mem_port_arbiter_if.slave  bus
);

    localparam int MASK_W      = mask_width(DATA_W);
    localparam int STREAK_BITS = streak_width(MAX_LS_BURST);
    localparam logic [STREAK_BITS-1:0] STREAK_MAX = STREAK_BITS'(MAX_LS_BURST);

    logic [STREAK_BITS-1:0] streak, streak_next;
    owner_t                 resp_owner, owner_next;
    logic                   if_gnt, ls_gnt;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        if_gnt = 1'b0;
        ls_gnt = 1'b0;
        if (bus.i_if_req && bus.i_ls_req) begin
            if (streak == STREAK_MAX) if_gnt = 1'b1;
            else                      ls_gnt = 1'b1;
        end else if (bus.i_if_req) begin
            if_gnt = 1'b1;
        end else if (bus.i_ls_req) begin
            ls_gnt = 1'b1;
        end
    end

    // Streak only measures how long a pending fetch has been passed over
    always_comb begin
        streak_next = streak;
        if (!bus.i_if_req || if_gnt) streak_next = '0;
        else if (ls_gnt && streak != STREAK_MAX) streak_next = streak + 1'b1;
    end

    always_comb begin
        owner_next = OWN_NONE;
        if (if_gnt)                       owner_next = OWN_IF;
        else if (ls_gnt && !bus.i_ls_wren) owner_next = OWN_LS;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample the same pre-edge values.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            streak     <= '0;
            resp_owner <= OWN_NONE;
        end else begin
            streak     <= streak_next;
            resp_owner <= owner_next;
        end
    end

    always_comb begin
        bus.o_mem_en    = 1'b0;
        bus.o_mem_wren  = 1'b0;
        bus.o_mem_addr  = '0;
        bus.o_mem_wdata = '0;
        bus.o_mem_bmask = '0;
        if (if_gnt) begin
            bus.o_mem_en    = 1'b1;
            bus.o_mem_addr  = bus.i_if_addr;
            bus.o_mem_bmask = '1;
        end else if (ls_gnt) begin
            bus.o_mem_en    = 1'b1;
            bus.o_mem_wren  = bus.i_ls_wren;
            bus.o_mem_addr  = bus.i_ls_addr;
            bus.o_mem_wdata = bus.i_ls_wdata;
            bus.o_mem_bmask = bus.i_ls_wren ? bus.i_ls_bmask : {MASK_W{1'b1}};
        end
    end

    assign bus.o_if_gnt    = if_gnt;
    assign bus.o_ls_gnt    = ls_gnt;
    assign bus.o_if_rvalid = (resp_owner == OWN_IF);
    assign bus.o_ls_rvalid = (resp_owner == OWN_LS);
    assign bus.o_if_rdata  = bus.o_if_rvalid ? bus.i_mem_rdata : '0;
    assign bus.o_ls_rdata  = bus.o_ls_rvalid ? bus.i_mem_rdata : '0;

`ifdef MEM_ARB_PERF_EN
    mem_arb_perf u_perf (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .conflict     (bus.i_if_req && bus.i_ls_req),
        .forced       (if_gnt && bus.i_ls_req),
        .conflict_cnt (bus.o_conflict_cnt),
        .starve_cnt   (bus.o_starve_cnt)
    );
`else
    assign bus.o_conflict_cnt = '0;
    assign bus.o_starve_cnt   = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table for grant/memory drive,
// plus hand-written sequences for latency, routing, starvation and reset corners.
module tb_mem_port_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
`ifdef MEM_ARB_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_LS_BURST(4)) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Synchronous single-port memory model with a side preload port
    logic [31:0] mem [0:255];
    logic        pre_we = 1'b0;
    logic [31:0] pre_addr = '0;
    logic [31:0] pre_data = '0;

    always @(posedge clk) begin
        if (pre_we) begin
            mem[pre_addr[9:2]] <= pre_data;
        end else if (bus.o_mem_en) begin
            if (bus.o_mem_wren) begin
                for (int b = 0; b < 4; b++)
                    if (bus.o_mem_bmask[b]) mem[bus.o_mem_addr[9:2]][8*b +: 8] <= bus.o_mem_wdata[8*b +: 8];
            end else begin
                bus.i_mem_rdata <= mem[bus.o_mem_addr[9:2]];
            end
        end
    end

    typedef struct {
        string       name;
        logic        if_req;
        logic [31:0] if_addr;
        logic        ls_req;
        logic        ls_wren;
        logic [31:0] ls_addr;
        logic [31:0] wdata;
        logic [3:0]  bmask;
        logic        e_if_gnt;
        logic        e_ls_gnt;
        logic        e_en;
        logic        e_wren;
        logic [31:0] e_addr;
        logic        chk_wdata;
        logic [31:0] e_wdata;
        logic [3:0]  e_bmask;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic if_req, input logic [31:0] if_addr, input logic ls_req,
                         input logic ls_wren, input logic [31:0] ls_addr,
                         input logic [31:0] wdata, input logic [3:0] bmask);
        bus.i_if_req   = if_req;
        bus.i_if_addr  = if_addr;
        bus.i_ls_req   = ls_req;
        bus.i_ls_wren  = ls_wren;
        bus.i_ls_addr  = ls_addr;
        bus.i_ls_wdata = wdata;
        bus.i_ls_bmask = bmask;
    endtask

    task automatic idle();
        drive(1'b0, '0, 1'b0, 1'b0, '0, '0, 4'h0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [31:0] addr, input logic [31:0] data);
        pre_addr = addr;
        pre_data = data;
        pre_we   = 1'b1;
        @(posedge clk);
        #1 pre_we = 1'b0;
    endtask

    // Holds both requests for n cycles; fetch must win only on the 5th
    task automatic burst_check(input string tag, input int n);
        for (int c = 0; c < n; c++) begin
            tick();
            drive(1'b1, 32'h80, 1'b1, 1'b0, 32'h100, '0, 4'h0);
            @(negedge clk);
            check($sformatf("%s_if_gnt_c%0d", tag, c), 32'(bus.o_if_gnt), 32'(c == 4));
            check($sformatf("%s_ls_gnt_c%0d", tag, c), 32'(bus.o_ls_gnt), 32'(c != 4));
        end
    endtask

    initial begin
        vecs[0] = '{"idle",       0, 32'h0,  0, 0, 32'h0,   32'h0,        4'h0, 0, 0, 0, 0, 32'h0,   1, 32'h0,        4'h0};
        vecs[1] = '{"fetch",      1, 32'h40, 0, 1, 32'h1F0, 32'h1111,     4'h3, 1, 0, 1, 0, 32'h40,  0, 32'h0,        4'hF};
        vecs[2] = '{"ls_load",    0, 32'h0,  1, 0, 32'h104, 32'h55,       4'h0, 0, 1, 1, 0, 32'h104, 1, 32'h55,       4'hF};
        vecs[3] = '{"ls_store",   0, 32'h0,  1, 1, 32'h108, 32'hCAFEF00D, 4'hA, 0, 1, 1, 1, 32'h108, 1, 32'hCAFEF00D, 4'hA};
        vecs[4] = '{"st_mask0",   0, 32'h0,  1, 1, 32'h10C, 32'h99999999, 4'h0, 0, 1, 1, 1, 32'h10C, 1, 32'h99999999, 4'h0};
        vecs[5] = '{"both_load",  1, 32'h44, 1, 0, 32'h110, 32'h2,        4'h5, 0, 1, 1, 0, 32'h110, 1, 32'h2,        4'hF};
        vecs[6] = '{"both_store", 1, 32'h48, 1, 1, 32'h114, 32'h3,        4'h6, 0, 1, 1, 1, 32'h114, 1, 32'h3,        4'h6};
        vecs[7] = '{"wren_noreq", 0, 32'h4C, 0, 1, 32'h118, 32'h4,        4'hF, 0, 0, 0, 0, 32'h0,   1, 32'h0,        4'h0};

        idle();
        bus.i_mem_rdata = '0;
        preload(32'h0,   32'h11110000);
        preload(32'h4,   32'h22220004);
        preload(32'h8,   32'h33330008);
        preload(32'h20,  32'h0F0F1234);
        preload(32'h100, 32'h12345678);
        preload(32'h10C, 32'hAABBCCDD);
        preload(32'h200, 32'h77778888);

        @(negedge clk);
        check("rst_if_rvalid", 32'(bus.o_if_rvalid), 32'h0);
        check("rst_ls_rvalid", 32'(bus.o_ls_rvalid), 32'h0);
        check("rst_if_rdata",  bus.o_if_rdata, 32'h0);
        check("rst_ls_rdata",  bus.o_ls_rdata, 32'h0);
        check("rst_mem_en",    32'(bus.o_mem_en), 32'h0);
        check("rst_conflict",  bus.o_conflict_cnt, 32'h0);
        check("rst_starve",    bus.o_starve_cnt, 32'h0);
        reset = 1'b0;

        // Starvation bound: 4 LSU grants, forced fetch, then the streak restarts
        burst_check("burst", 5);
        tick();
        drive(1'b1, 32'h80, 1'b1, 1'b0, 32'h100, '0, 4'h0);
        @(negedge clk);
        check("burst_restart_ls_gnt", 32'(bus.o_ls_gnt), 32'h1);
        check("burst_restart_if_gnt", 32'(bus.o_if_gnt), 32'h0);
        check("burst_conflict_cnt", bus.o_conflict_cnt, PERF ? 32'd5 : 32'd0);
        check("burst_starve_cnt",   bus.o_starve_cnt,   PERF ? 32'd1 : 32'd0);
        tick();
        idle();

        // Grant and memory-drive table, each vector followed by an idle response cycle
        for (int i = 0; i < 8; i++) begin
            tick();
            drive(vecs[i].if_req, vecs[i].if_addr, vecs[i].ls_req, vecs[i].ls_wren,
                  vecs[i].ls_addr, vecs[i].wdata, vecs[i].bmask);
            @(negedge clk);
            check({vecs[i].name, "_if_gnt"},   32'(bus.o_if_gnt),   32'(vecs[i].e_if_gnt));
            check({vecs[i].name, "_ls_gnt"},   32'(bus.o_ls_gnt),   32'(vecs[i].e_ls_gnt));
            check({vecs[i].name, "_mem_en"},   32'(bus.o_mem_en),   32'(vecs[i].e_en));
            check({vecs[i].name, "_mem_wren"}, 32'(bus.o_mem_wren), 32'(vecs[i].e_wren));
            check({vecs[i].name, "_mem_addr"}, bus.o_mem_addr,      vecs[i].e_addr);
            check({vecs[i].name, "_bmask"},    32'(bus.o_mem_bmask), 32'(vecs[i].e_bmask));
            if (vecs[i].chk_wdata) check({vecs[i].name, "_wdata"}, bus.o_mem_wdata, vecs[i].e_wdata);
            tick();
            idle();
            @(negedge clk);
            check({vecs[i].name, "_if_rvalid"}, 32'(bus.o_if_rvalid), 32'(vecs[i].e_if_gnt));
            check({vecs[i].name, "_ls_rvalid"}, 32'(bus.o_ls_rvalid),
                  32'(vecs[i].e_ls_gnt && !vecs[i].e_wren));
        end

        // Back-to-back fetches with 1-cycle read latency
        tick(); drive(1'b1, 32'h0, 1'b0, 1'b0, '0, '0, 4'h0);
        @(negedge clk);
        check("f0_gnt", 32'(bus.o_if_gnt), 32'h1);
        check("f0_rvalid", 32'(bus.o_if_rvalid), 32'h0);
        tick(); drive(1'b1, 32'h4, 1'b0, 1'b0, '0, '0, 4'h0);
        @(negedge clk);
        check("f1_gnt", 32'(bus.o_if_gnt), 32'h1);
        check("f1_rvalid", 32'(bus.o_if_rvalid), 32'h1);
        check("f1_rdata", bus.o_if_rdata, 32'h11110000);
        tick(); drive(1'b1, 32'h8, 1'b0, 1'b0, '0, '0, 4'h0);
        @(negedge clk);
        check("f2_rdata", bus.o_if_rdata, 32'h22220004);
        tick(); idle();
        @(negedge clk);
        check("f3_rdata", bus.o_if_rdata, 32'h33330008);
        tick();
        @(negedge clk);
        check("f4_rvalid", 32'(bus.o_if_rvalid), 32'h0);

        // Partial store then load-back; masked-off store leaves 0x10C intact
        tick(); drive(1'b0, '0, 1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 4'b0011);
        @(negedge clk);
        check("st_gnt", 32'(bus.o_ls_gnt), 32'h1);
        tick(); drive(1'b0, '0, 1'b1, 1'b0, 32'h100, '0, 4'h0);
        @(negedge clk);
        check("st_no_rvalid", 32'(bus.o_ls_rvalid), 32'h0);
        tick(); drive(1'b0, '0, 1'b1, 1'b0, 32'h10C, '0, 4'h0);
        @(negedge clk);
        check("ld_rvalid", 32'(bus.o_ls_rvalid), 32'h1);
        check("ld_merged", bus.o_ls_rdata, 32'h1234BEEF);
        tick(); idle();
        @(negedge clk);
        check("ld_mask0_word", bus.o_ls_rdata, 32'hAABBCCDD);
        tick();
        @(negedge clk);
        check("ld_rvalid_drop", 32'(bus.o_ls_rvalid), 32'h0);
        check("ld_rdata_zero", bus.o_ls_rdata, 32'h0);

        // Fetch then LSU load: responses on consecutive cycles, no cross-routing
        tick(); drive(1'b1, 32'h20, 1'b0, 1'b0, '0, '0, 4'h0);
        tick(); drive(1'b0, '0, 1'b1, 1'b0, 32'h200, '0, 4'h0);
        @(negedge clk);
        check("rt_if_rvalid", 32'(bus.o_if_rvalid), 32'h1);
        check("rt_if_rdata", bus.o_if_rdata, 32'h0F0F1234);
        check("rt_ls_idle", 32'(bus.o_ls_rvalid), 32'h0);
        check("rt_ls_rdata0", bus.o_ls_rdata, 32'h0);
        tick(); idle();
        @(negedge clk);
        check("rt_ls_rvalid", 32'(bus.o_ls_rvalid), 32'h1);
        check("rt_ls_rdata", bus.o_ls_rdata, 32'h77778888);
        check("rt_if_idle", 32'(bus.o_if_rvalid), 32'h0);
        check("rt_if_rdata0", bus.o_if_rdata, 32'h0);

        // Async reset mid-cycle with a load outstanding and streak at 2
        tick(); drive(1'b1, 32'h80, 1'b1, 1'b0, 32'h200, '0, 4'h0);
        tick();
        @(negedge clk);
        check("pre_rst_ls_gnt", 32'(bus.o_ls_gnt), 32'h1);
        @(posedge clk);
        #2;
        idle();
        reset = 1'b1;
        #1;
        check("arst_ls_rvalid", 32'(bus.o_ls_rvalid), 32'h0);
        check("arst_ls_rdata", bus.o_ls_rdata, 32'h0);
        check("arst_conflict", bus.o_conflict_cnt, 32'h0);
        check("arst_starve", bus.o_starve_cnt, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        @(negedge clk);
        check("post_rst_ls_rvalid", 32'(bus.o_ls_rvalid), 32'h0);
        check("post_rst_if_rvalid", 32'(bus.o_if_rvalid), 32'h0);

        // Idle cycles: nothing granted, nothing returned
        for (int c = 0; c < 3; c++) begin
            tick();
            @(negedge clk);
            check($sformatf("idle%0d_mem_en", c), 32'(bus.o_mem_en), 32'h0);
            check($sformatf("idle%0d_gnts", c), {30'h0, bus.o_if_gnt, bus.o_ls_gnt}, 32'h0);
            check($sformatf("idle%0d_rvalids", c), {30'h0, bus.o_if_rvalid, bus.o_ls_rvalid}, 32'h0);
        end

        // Streak must have restarted from 0 after reset and idle
        burst_check("post", 5);
        tick(); idle();
        @(negedge clk);
        check("post_conflict_cnt", bus.o_conflict_cnt, PERF ? 32'd5 : 32'd0);
        check("post_starve_cnt",   bus.o_starve_cnt,   PERF ? 32'd1 : 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-port synchronous memory between the instruction-fetch path (PC-addressed) and the LSU data path, so that code and data can live in a single physical RAM. Each cycle it grants one requester and drives the memory port. It tags every read, routes the 1-cycle-latency read data back to its owner, and bounds fetch starvation with a streak counter. It sits between pc_reg/LSU and the memory macro; the core stalls on `!o_if_gnt`.

Parameters:
ADDR_W, 32, byte address width on all ports
DATA_W, 32, data width; byte mask width = DATA_W/8
MAX_LS_BURST, 4, max consecutive LSU grants while fetch is pending (legal 1..15)

Ports:
i_clk  in  1  clock; all state updates on rising edge
i_reset  in  1  asynchronous, active-high reset
i_if_req  in  1  fetch request, held until granted
i_if_addr  in  ADDR_W  fetch byte address
o_if_gnt  out  1  fetch granted this cycle (combinational)
o_if_rvalid  out  1  fetch read data valid (registered tag)
o_if_rdata  out  DATA_W  fetch read data; 0 when `!o_if_rvalid`
i_ls_req  in  1  LSU request, held until granted
i_ls_wren  in  1  1 = store, 0 = load
i_ls_addr  in  ADDR_W  LSU byte address
i_ls_wdata  in  DATA_W  store data
i_ls_bmask  in  DATA_W/8  store byte enables
o_ls_gnt  out  1  LSU granted this cycle (combinational)
o_ls_rvalid  out  1  load data valid
o_ls_rdata  out  DATA_W  load data; 0 when `!o_ls_rvalid`
o_mem_en  out  1  memory access this cycle
o_mem_wren  out  1  memory write
o_mem_addr  out  ADDR_W  memory byte address
o_mem_wdata  out  DATA_W  memory write data
o_mem_bmask  out  DATA_W/8  memory byte enables
i_mem_rdata  in  DATA_W  memory read data, valid 1 cycle after read enable
o_conflict_cnt  out  32  perf counter (see Optional Feature)
o_starve_cnt  out  32  perf counter (see Optional Feature)

Behaviour:
- Reset (async, active-high): streak counter = 0, resp_owner = NONE, perf counters = 0. Consequently all rvalid = 0 and all rdata = 0. Grants remain combinational from the request inputs.
- Grant rule (combinational, at most one grant per cycle):
  - only one requester active → grant it;
  - both active and `streak == MAX_LS_BURST` → grant fetch (forced grant);
  - both active otherwise → grant LSU.
- Streak counter:
  - +1 on each LSU grant while `i_if_req` = 1;
  - cleared on any fetch grant or any cycle with `i_if_req` = 0;
  - never exceeds MAX_LS_BURST.
- Memory drive:
  - `o_mem_en` = any grant.
  - Fetch grant → `o_mem_wren` = 0, addr = `i_if_addr`, bmask = all ones.
  - LSU grant → `o_mem_wren` = `i_ls_wren`, addr = `i_ls_addr`, wdata = `i_ls_wdata`. bmask = `i_ls_bmask` on stores, all ones on loads.
  - No grant → `o_mem_en` = 0, `o_mem_wren` = 0, addr/wdata/bmask = 0.
- Response path:
  - resp_owner is registered each cycle: IF after a fetch grant, LS after an LSU load grant, NONE after a store or no grant.
  - Read latency is exactly 1 cycle: rvalid of the owner = 1 in the cycle after its grant, with rdata = `i_mem_rdata`.
  - Stores never produce rvalid.
- Back-to-back grants are allowed every cycle, with no bubbles.
- A store with bmask = 0 is still granted and drives `o_mem_en`/`o_mem_wren`; the memory content is unchanged.
- Reset asserted with a read outstanding: the response is dropped and no rvalid appears after reset.
- Address is passed through unmodified; alignment is the requester's responsibility.

Optional Feature:
Macro MEM_ARB_PERF_EN.
- Defined:
  - `o_conflict_cnt` +1 on every cycle with both requests high.
  - `o_starve_cnt` +1 on every forced fetch grant.
  - Both counters saturate at 32'hFFFF_FFFF and clear on reset.
- Undefined: both ports are tied to 0 and no counter flops are inferred.

Decomposition:
- Package mem_arb_pkg:
  - owner enum {OWN_NONE, OWN_IF, OWN_LS};
  - streak width localparam derived from MAX_LS_BURST via $clog2(MAX_LS_BURST+1);
  - DATA_W/8 mask-width function.
- Sub-module mem_arb_perf holds the two saturating counters and is instantiated only under MEM_ARB_PERF_EN.
- Grant, streak and response logic stay in the top module.

Test Plan:
1. Fetch only, addr 0x0, 0x4, 0x8 on consecutive cycles → grant every cycle; `o_if_rvalid` 1 cycle later each time, with `o_if_rdata` = memory words at those addresses.
2. Both requesters held high, MAX_LS_BURST = 4, LSU loads → LSU granted 4 cycles, fetch granted on the 5th, then streak restarts. With the macro, `o_starve_cnt` = 1 and `o_conflict_cnt` = 5.
3. LSU store addr 0x100, wdata 0xDEADBEEF, bmask 4'b0011, then load 0x100 (memory preloaded with 0x12345678) → no rvalid after the store; `o_ls_rdata` = 0x1234BEEF one cycle after the load grant.
4. Fetch load at 0x20, then an LSU load the next cycle → `o_if_rvalid` and `o_ls_rvalid` on consecutive cycles, each carrying its own data with no cross-routing.
5. Reset pulsed asynchronously (mid-cycle) while a load is outstanding → rvalid stays 0 after reset, streak = 0, counters = 0.
6. No requests for 3 cycles → `o_mem_en` = 0 and all gnt/rvalid = 0; streak stays 0.
